// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave fronting a bank of read/write control registers.
// Independent write and read paths, one outstanding transaction each.
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int AL = $clog2(STRB_WIDTH);
  localparam int IW = ADDR_WIDTH - AL;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                  aw_full_q, aw_full_d;
  logic                  w_full_q, w_full_d;
  logic [IW-1:0]         aw_idx_q;
  logic [IW-1:0]         ar_idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  awready_q, wready_q;
  logic                  bvalid_q, arready_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  wr_in_range, rd_in_range;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused;

  assign aw_hs  = s_axil_awvalid && awready_q;
  assign w_hs   = s_axil_wvalid && wready_q;
  assign ar_hs  = s_axil_arvalid && arready_q;
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:AL];
  assign wr_in_range = 32'(aw_idx_q) < 32'(NUM_REGS);
  assign rd_in_range = 32'(ar_idx) < 32'(NUM_REGS);

  assign aw_full_d = commit ? 1'b0 : (aw_full_q || aw_hs);
  assign w_full_d  = commit ? 1'b0 : (w_full_q || w_hs);

  assign unused = ^{s_axil_awprot, s_axil_arprot,
                    s_axil_awaddr[AL-1:0], s_axil_araddr[AL-1:0]};

  // Out-of-range indices match no register, so they read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == 32'(i)) rd_val = regs_q[i];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (commit && wr_in_range) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (32'(aw_idx_q) == 32'(i)) begin
            pulse_q[i] <= 1'b1;
            for (int b = 0; b < STRB_WIDTH; b++) begin
              if (wstrb_q[b]) regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awready_q <= !aw_full_d;
      wready_q  <= !w_full_d;
      if (aw_hs) aw_idx_q <= s_axil_awaddr[ADDR_WIDTH-1:AL];
      if (w_hs) begin
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? OKAY : SLVERR;
      end else if (bvalid_q && s_axil_bready) begin
        bvalid_q <= 1'b0;
        bresp_q  <= OKAY;
      end
      if (ar_hs) begin
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_val;
        rresp_q   <= rd_in_range ? OKAY : SLVERR;
        arready_q <= 1'b0;
      end else if (rvalid_q && s_axil_rready) begin
        rvalid_q  <= 1'b0;
        rdata_q   <= '0;
        rresp_q   <= OKAY;
        arready_q <= 1'b1;
      end else begin
        arready_q <= !rvalid_q;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_wr_pulse   = pulse_q;

endmodule
